// File: rtl/demux_rr_dispatcher.sv
// rtl/demux_rr_dispatcher.sv - FIFO-buffered round-robin bit dispatcher feeding a 1-to-4 demux
module demux_rr_dispatcher #(
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_bit,
  output logic                       in_ready,
  input  logic [3:0]                 lane_en,
  input  logic [3:0]                 lane_busy,
  output logic                       i,
  output logic [1:0]                 sel,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYC - 1);

  localparam logic IDLE  = 1'b0;
  localparam logic DRIVE = 1'b1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [1:0]       ptr;
  logic [HW-1:0]    hold;
  logic             state;

  logic [3:0] elig;
  logic [1:0] chosen;
  logic [1:0] idx;
  logic       found;
  logic       decide;
  logic       dispatch;
  logic       push;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign elig     = lane_en & ~lane_busy;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    found  = 1'b0;
    chosen = ptr;
    idx    = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (elig[idx]) begin
        found  = 1'b1;
        chosen = idx;
      end
    end
  end

  assign decide   = (state == IDLE) || (hold == '0);
  assign dispatch = decide && !empty && found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_bit;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (dispatch) rd_ptr <= rd_ptr + 1'b1;
      case ({push, dispatch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A held dispatch ignores lane changes; a new decision happens only when the hold expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i         <= 1'b0;
      sel       <= 2'd0;
      out_valid <= 1'b0;
      ptr       <= 2'd0;
      hold      <= '0;
      state     <= IDLE;
    end else if (dispatch) begin
      sel       <= chosen;
      i         <= mem[rd_ptr];
      out_valid <= 1'b1;
      ptr       <= chosen + 2'd1;
      hold      <= HOLD_INIT;
      state     <= DRIVE;
    end else if (decide) begin
      i         <= 1'b0;
      out_valid <= 1'b0;
      state     <= IDLE;
    end else begin
      hold <= hold - 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// tb/tb_demux_rr_dispatcher.sv - table-driven bench for demux_rr_dispatcher
module tb_demux_rr_dispatcher;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_bit, in_ready;
  logic [3:0] lane_en, lane_busy;
  logic       i, out_valid;
  logic [1:0] sel;
  logic [2:0] count;
  logic       empty, full;

  logic       in_valid3, in_bit3, in_ready3;
  logic [3:0] lane_en3, lane_busy3;
  logic       i3, out_valid3;
  logic [1:0] sel3;
  logic [2:0] count3;
  logic       empty3, full3;

  int total = 0;
  int bad   = 0;
  int vidx  = 0;

  demux_rr_dispatcher #(.DEPTH(4), .HOLD_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .lane_en(lane_en), .lane_busy(lane_busy), .i(i), .sel(sel), .out_valid(out_valid),
    .count(count), .empty(empty), .full(full)
  );

  demux_rr_dispatcher #(.DEPTH(4), .HOLD_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_bit(in_bit3), .in_ready(in_ready3),
    .lane_en(lane_en3), .lane_busy(lane_busy3), .i(i3), .sel(sel3), .out_valid(out_valid3),
    .count(count3), .empty(empty3), .full(full3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en;
    logic [3:0] busy;
    logic       v;
    logic       b;
    logic       ev;
    logic       ei;
    logic [1:0] esel;
    int         ecnt;
    logic       erdy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step=%0d: got %0d want %0d", name, vidx, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] en, input logic [3:0] busy, input logic v, input logic b,
                     input logic ev, input logic ei, input logic [1:0] esel, input int ecnt,
                     input logic erdy);
    vecs.push_back('{en, busy, v, b, ev, ei, esel, ecnt, erdy});
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_bit = 0; lane_en = 4'h0; lane_busy = 4'h0;
    in_valid3 = 0; in_bit3 = 0; lane_en3 = 4'h0; lane_busy3 = 4'h0;

    // round robin over all lanes
    add(4'hF, 4'h0, 1, 1, 0, 0, 0, 1, 1);
    add(4'hF, 4'h0, 1, 0, 1, 1, 0, 1, 1);
    add(4'hF, 4'h0, 1, 1, 1, 0, 1, 1, 1);
    add(4'hF, 4'h0, 1, 1, 1, 1, 2, 1, 1);
    add(4'hF, 4'h0, 1, 1, 1, 1, 3, 1, 1);
    add(4'hF, 4'h0, 0, 0, 1, 1, 0, 0, 1);
    add(4'hF, 4'h0, 0, 0, 0, 0, 0, 0, 1);
    // disabled lanes skipped
    add(4'hA, 4'h0, 1, 1, 0, 0, 0, 1, 1);
    add(4'hA, 4'h0, 1, 1, 1, 1, 1, 1, 1);
    add(4'hA, 4'h0, 1, 1, 1, 1, 3, 1, 1);
    add(4'hA, 4'h0, 1, 1, 1, 1, 1, 1, 1);
    add(4'hA, 4'h0, 0, 0, 1, 1, 3, 0, 1);
    add(4'hA, 4'h0, 0, 0, 0, 0, 3, 0, 1);
    // move ptr to 1, then busy lane 1 skipped
    add(4'hF, 4'h0, 1, 0, 0, 0, 3, 1, 1);
    add(4'hF, 4'h0, 0, 0, 1, 0, 0, 0, 1);
    add(4'hF, 4'h0, 1, 1, 0, 0, 0, 1, 1);
    add(4'hF, 4'h2, 1, 1, 1, 1, 2, 1, 1);
    add(4'hF, 4'h2, 0, 0, 1, 1, 3, 0, 1);
    add(4'hF, 4'h0, 0, 0, 0, 0, 3, 0, 1);
    // fill with no lanes, reject while full, release one
    add(4'h0, 4'h0, 1, 1, 0, 0, 3, 1, 1);
    add(4'h0, 4'h0, 1, 0, 0, 0, 3, 2, 1);
    add(4'h0, 4'h0, 1, 1, 0, 0, 3, 3, 1);
    add(4'h0, 4'h0, 1, 1, 0, 0, 3, 4, 0);
    add(4'h0, 4'h0, 1, 0, 0, 0, 3, 4, 0);
    add(4'h1, 4'h0, 1, 0, 1, 1, 0, 3, 1);
    add(4'h0, 4'h0, 1, 0, 0, 0, 0, 4, 0);
    // drain in order, ptr resumes at 1
    add(4'hF, 4'h0, 0, 0, 1, 0, 1, 3, 1);
    add(4'hF, 4'h0, 0, 0, 1, 1, 2, 2, 1);
    add(4'hF, 4'h0, 0, 0, 1, 1, 3, 1, 1);
    add(4'hF, 4'h0, 0, 0, 1, 0, 0, 0, 1);
    add(4'hF, 4'h0, 0, 0, 0, 0, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_i", i, 0);
    chk("rst_sel", sel, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      vidx = n;
      lane_en = vecs[n].en; lane_busy = vecs[n].busy;
      in_valid = vecs[n].v; in_bit = vecs[n].b;
      @(posedge clk);
      #1;
      chk("out_valid", out_valid, vecs[n].ev);
      chk("i", i, vecs[n].ei);
      chk("sel", sel, vecs[n].esel);
      chk("count", count, vecs[n].ecnt);
      chk("in_ready", in_ready, vecs[n].erdy);
      chk("empty", empty, (vecs[n].ecnt == 0) ? 1 : 0);
      chk("full", full, (vecs[n].ecnt == 4) ? 1 : 0);
    end

    // hold of three cycles per bit, back-to-back
    vidx = 100;
    lane_en3 = 4'hF; in_valid3 = 1; in_bit3 = 1;
    @(posedge clk); #1;
    chk("h_idle_valid", out_valid3, 0);
    in_bit3 = 0;
    @(posedge clk); #1;
    in_valid3 = 0;
    for (int c = 0; c < 6; c++) begin
      vidx = 101 + c;
      chk("h_valid", out_valid3, 1);
      chk("h_i", i3, (c < 3) ? 1 : 0);
      chk("h_sel", sel3, (c < 3) ? 0 : 1);
      @(posedge clk); #1;
    end
    vidx = 107;
    chk("h_end_valid", out_valid3, 0);
    chk("h_end_i", i3, 0);
    chk("h_end_count", count3, 0);

    // asynchronous reset in the middle of a held dispatch
    vidx = 200;
    lane_en3 = 4'h0; in_valid3 = 1; in_bit3 = 1;
    @(posedge clk); #1;
    in_valid3 = 1; in_bit3 = 1;
    @(posedge clk); #1;
    in_valid3 = 0; lane_en3 = 4'h4;
    @(posedge clk); #1;
    chk("pre_rst_valid", out_valid3, 1);
    chk("pre_rst_sel", sel3, 2);
    chk("pre_rst_count", count3, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid3, 0);
    chk("mid_rst_i", i3, 0);
    chk("mid_rst_sel", sel3, 0);
    chk("mid_rst_count", count3, 0);
    chk("mid_rst_ready", in_ready3, 1);
    chk("mid_rst_empty", empty3, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    lane_en3 = 4'h0;
    @(posedge clk); #1;
    chk("post_rst_count", count3, 0);
    chk("post_rst_valid", out_valid3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
